// File: rtl/aes_encode_arbiter.sv
// aes_encode_arbiter
//
// Purpose:
//   Shares one pipelined AES encoder between two independent requesters
//   (channel 0 and channel 1). Accepted blocks are registered onto the
//   encoder input, slot ownership is tracked by a tag shift register that
//   runs alongside the encoder pipeline, and each ciphertext is steered into
//   a per-channel output FIFO. The encoder cannot stall, so a channel is only
//   granted while it holds credit:
//     credit = OUT_DEPTH - fifo_count - inflight.
//
// Build option:
//   AES_ARB_STRICT_PRIO_EN - when defined, channel 0 always wins a tie
//                            (fixed priority). Default build is round-robin.
//
// Parameters:
//   KEY_SIZE  - key width in bits (128/192/256)
//   LATENCY   - encoder latency: enc_valid arrives LATENCY edges after the
//               edge that loaded enc_plain/enc_key
//   OUT_DEPTH - entries per channel output FIFO (power of two, 2..16)
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   asynchronous active-low reset
//   req_valid   in   [1:0] channel i presents a block
//   req_ready   out  [1:0] channel i accepted this cycle (grant)
//   req_plain   in   {ch1,ch0} 128-bit plaintexts
//   req_key     in   {ch1,ch0} keys
//   enc_plain   out  registered encoder data input
//   enc_key     out  registered encoder key input
//   enc_out     in   encoder ciphertext
//   enc_valid   in   encoder output valid
//   resp_valid  out  [1:0] channel FIFO non-empty
//   resp_ready  in   [1:0] channel consumer pop
//   resp_data   out  {ch1,ch0} FIFO heads
//   err         out  sticky protocol error (cleared only by reset)

module aes_encode_arbiter #(
  parameter int KEY_SIZE  = 128,
  parameter int LATENCY   = 10,
  parameter int OUT_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [255:0]          req_plain,
  input  logic [2*KEY_SIZE-1:0] req_key,
  output logic [127:0]          enc_plain,
  output logic [KEY_SIZE-1:0]   enc_key,
  input  logic [127:0]          enc_out,
  input  logic                  enc_valid,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [255:0]          resp_data,
  output logic                  err
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW+1)'(OUT_DEPTH);

  logic [1:0]          w_elig;
  logic [1:0]          w_grant;
  logic                w_grant_ch;
  logic                w_tail_v;
  logic                w_tail_ch;

  logic [127:0]        r_enc_plain;
  logic [KEY_SIZE-1:0] r_enc_key;
  logic                r_err;

  // Tag pipe: bit 0 is loaded together with the encoder input; the top bit
  // lines up with enc_valid for that block.
  logic [LATENCY:0]    r_tag_v;
  logic [LATENCY:0]    r_tag_ch;

  assign w_tail_v  = r_tag_v[LATENCY];
  assign w_tail_ch = r_tag_ch[LATENCY];

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifdef AES_ARB_STRICT_PRIO_EN
  always_comb begin
    w_grant = 2'b00;
    if (w_elig[0]) begin
      w_grant = 2'b01;
    end else if (w_elig[1]) begin
      w_grant = 2'b10;
    end
  end
`else
  logic r_last_grant;

  always_comb begin
    w_grant = 2'b00;
    case (w_elig)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      // Tie: the channel that did not win last time goes first.
      2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
    end else if (|w_grant) begin
      r_last_grant <= w_grant[1];
    end
  end
`endif

  assign w_grant_ch = w_grant[1];
  // Nothing is accepted while reset holds the state registers.
  assign req_ready  = w_grant & {2{reset}};

  // ---------------------------------------------------------------------
  // Issue to encoder and tag tracking
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_enc_plain <= '0;
      r_enc_key   <= '0;
      r_tag_v     <= '0;
      r_tag_ch    <= '0;
    end else begin
      if (|w_grant) begin
        r_enc_plain <= w_grant_ch ? req_plain[255:128] : req_plain[127:0];
        r_enc_key   <= w_grant_ch ? req_key[2*KEY_SIZE-1:KEY_SIZE]
                                  : req_key[KEY_SIZE-1:0];
      end
      r_tag_v  <= {r_tag_v[LATENCY-1:0],  |w_grant};
      r_tag_ch <= {r_tag_ch[LATENCY-1:0], w_grant_ch};
    end
  end

  assign enc_plain = r_enc_plain;
  assign enc_key   = r_enc_key;

  // Any disagreement between enc_valid and the tail tag is a protocol error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (enc_valid != w_tail_v) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  // ---------------------------------------------------------------------
  // Per-channel credit, in-flight count and output FIFO
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [127:0]  r_mem [OUT_DEPTH];
    logic [CW-1:0] r_wptr;
    logic [CW-1:0] r_rptr;
    logic [CW-1:0] r_infl;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_used;
    logic          w_empty;
    logic          w_full;
    logic          w_retire;
    logic          w_push;
    logic          w_pop;

    assign w_count  = r_wptr - r_rptr;
    assign w_used   = {1'b0, w_count} + {1'b0, r_infl};
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // A valid tail tag retires its slot even if the data never showed up.
    assign w_retire = w_tail_v && (w_tail_ch == 1'(gi));
    assign w_push   = w_retire && enc_valid;
    assign w_pop    = !w_empty && resp_ready[gi];

    assign w_elig[gi]            = req_valid[gi] && (w_used < DEPTH_EXT);
    assign resp_valid[gi]        = !w_empty;
    assign resp_data[128*gi +: 128] = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_infl <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        // Grant and retire on the same edge cancel out.
        case ({w_grant[gi], w_retire})
          2'b10:   r_infl <= r_infl + 1'b1;
          2'b01:   r_infl <= r_infl - 1'b1;
          default: r_infl <= r_infl;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= enc_out;
      end
    end

    // Credit accounting makes a push into a full FIFO unreachable.
    a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
      !(w_push && w_full && !w_pop));
  end

endmodule

// File: tb/tb_aes_encode_arbiter.sv
`timescale 1ns/1ps
module tb_aes_encode_arbiter;
  localparam int KEY_SIZE  = 128;
  localparam int LATENCY   = 10;
  localparam int OUT_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [1:0]            req_valid = '0;
  logic [1:0]            req_ready;
  logic [255:0]          req_plain = '0;
  logic [2*KEY_SIZE-1:0] req_key = '0;
  logic [127:0]          enc_plain;
  logic [KEY_SIZE-1:0]   enc_key;
  logic [127:0]          enc_out;
  logic                  enc_valid;
  logic [1:0]            resp_valid;
  logic [1:0]            resp_ready = '0;
  logic [255:0]          resp_data;
  logic                  err;
  logic                  inj = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_encode_arbiter #(.KEY_SIZE(KEY_SIZE), .LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clock(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_plain(req_plain), .req_key(req_key), .enc_plain(enc_plain), .enc_key(enc_key),
    .enc_out(enc_out), .enc_valid(enc_valid), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .err(err)
  );

  // ------------------------------------------------------------------
  // Behavioural AES-128
  // ------------------------------------------------------------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] t0, rcon;
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        t0 = tmp[0];
        tmp[0] = sbox[tmp[1]] ^ rcon;
        tmp[1] = sbox[tmp[2]];
        tmp[2] = sbox[tmp[3]];
        tmp[3] = sbox[t0];
        rcon = xt(rcon);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) t[4*c+k] = sbox[s[4*((c+k)%4)+k]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ------------------------------------------------------------------
  // Encoder model: fixed LATENCY pipeline, shares the reset net
  // ------------------------------------------------------------------
  logic               m_g;
  logic [LATENCY:1]   m_v;
  logic [127:0]       m_d [1:LATENCY];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_g <= 1'b0;
      m_v <= '0;
    end else begin
      m_g    <= |(req_valid & req_ready);
      m_v[1] <= m_g;
      m_d[1] <= m_g ? aes128(enc_plain, enc_key) : 128'h0;
      for (int s = 2; s <= LATENCY; s++) begin
        m_v[s] <= m_v[s-1];
        m_d[s] <= m_d[s-1];
      end
    end
  end

  assign enc_valid = m_v[LATENCY] | inj;
  assign enc_out   = m_d[LATENCY];

  // ------------------------------------------------------------------
  // Reference model: accepted-but-not-popped blocks per channel, expected
  // and observed response streams, last granted channel
  // ------------------------------------------------------------------
  logic [127:0] exp0 [$];
  logic [127:0] exp1 [$];
  logic [127:0] got0 [$];
  logic [127:0] got1 [$];
  int outst [2];
  int acc_cnt [2];
  int last_g;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
      outst[0] = 0; outst[1] = 0;
      last_g = 1;
    end else begin
      if (req_valid[0] && req_ready[0]) begin
        exp0.push_back(aes128(req_plain[127:0], req_key[127:0]));
        outst[0]++; acc_cnt[0]++; last_g = 0;
      end
      if (req_valid[1] && req_ready[1]) begin
        exp1.push_back(aes128(req_plain[255:128], req_key[255:128]));
        outst[1]++; acc_cnt[1]++; last_g = 1;
      end
      if (resp_valid[0] && resp_ready[0]) begin
        got0.push_back(resp_data[127:0]); outst[0]--;
      end
      if (resp_valid[1] && resp_ready[1]) begin
        got1.push_back(resp_data[255:128]); outst[1]--;
      end
    end
  end

  function automatic logic [1:0] exp_grant(input logic [1:0] v);
    logic [1:0] e;
    e[0] = v[0] && (outst[0] < OUT_DEPTH);
    e[1] = v[1] && (outst[1] < OUT_DEPTH);
    if (e == 2'b11) begin
`ifdef AES_ARB_STRICT_PRIO_EN
      return 2'b01;
`else
      return (last_g == 0) ? 2'b10 : 2'b01;
`endif
    end
    return e;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [1:0] rr);
    @(negedge clk);
    req_valid  = v;
    resp_ready = rr;
    for (int i = 0; i < 8; i++) begin
      req_plain[32*i +: 32] = $urandom();
      req_key[32*i +: 32]   = $urandom();
    end
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (outst[0] == 0 && outst[1] == 0 && resp_valid == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    resp_ready = 2'b00;
  endtask

  task automatic clear_q();
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
  endtask

  // ------------------------------------------------------------------
  // Tests
  // ------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b11, 2'b11);
    checks++; if (enc_plain !== 128'h0) begin errors++; $display("FAIL reset_enc_plain got %h exp 0", enc_plain); end
    checks++; if (enc_key !== '0) begin errors++; $display("FAIL reset_enc_key got %h exp 0", enc_key); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", resp_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    @(negedge clk);
    req_valid = 2'b00; resp_ready = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL reset_idle got valid=%b err=%b exp 00/0", resp_valid, err); end
    $display("test_reset done");
  endtask

  task automatic test_single_block();
    int n;
    clear_q();
    @(negedge clk);
    req_valid = 2'b01;
    req_plain[127:0] = 128'h00112233445566778899aabbccddeeff;
    req_key[127:0]   = 128'h000102030405060708090a0b0c0d0e0f;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (enc_plain !== 128'h00112233445566778899aabbccddeeff) begin errors++; $display("FAIL single_enc_plain got %h", enc_plain); end
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != LATENCY + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d", n, LATENCY + 1); end
    checks++; if (resp_data[127:0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL single_data got %h exp 69c4e0d86a7b0430d8cdb78070b4c55a", resp_data[127:0]); end
    checks++; if (resp_valid[1] !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL single_side got valid1=%b err=%b exp 0/0", resp_valid[1], err); end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL single_pop got valid=%b exp 00", resp_valid); end
    $display("test_single_block done: latency %0d", n);
  endtask

  task automatic test_round_robin();
    bit ok;
    clear_q();
    for (int c = 0; c < 20; c++) begin
      drive(2'b11, 2'b11);
      checks++; if (req_ready !== exp_grant(req_valid)) begin errors++; $display("FAIL rr_grant cycle %0d got %b exp %b", c, req_ready, exp_grant(req_valid)); end
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_drain timeout outstanding %0d/%0d", outst[0], outst[1]); end
    checks++; if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin errors++; $display("FAIL rr_count got %0d/%0d exp %0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL rr_data0[%0d] got %h exp %h", i, got0[i], exp0[i]); end end
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL rr_data1[%0d] got %h exp %h", i, got1[i], exp1[i]); end end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rr_err got %b exp 0", err); end
    $display("test_round_robin done: %0d/%0d results", got0.size(), got1.size());
  endtask

  task automatic test_backpressure();
    bit ok;
    int base1;
    clear_q();
    base1 = acc_cnt[1];
    for (int c = 0; c < 30; c++) begin
      drive(2'b11, 2'b01);
      checks++; if (req_ready !== exp_grant(req_valid)) begin errors++; $display("FAIL bp_grant cycle %0d got %b exp %b", c, req_ready, exp_grant(req_valid)); end
    end
    checks++; if (acc_cnt[1] - base1 != OUT_DEPTH) begin errors++; $display("FAIL bp_ch1_accepts got %0d exp %0d", acc_cnt[1] - base1, OUT_DEPTH); end
    for (int c = 0; c < 20; c++) begin
      drive(2'b11, 2'b11);
      checks++; if (req_ready !== exp_grant(req_valid)) begin errors++; $display("FAIL bp_release_grant cycle %0d got %b exp %b", c, req_ready, exp_grant(req_valid)); end
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain timeout outstanding %0d/%0d", outst[0], outst[1]); end
    checks++; if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin errors++; $display("FAIL bp_count got %0d/%0d exp %0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL bp_data0[%0d] got %h exp %h", i, got0[i], exp0[i]); end end
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL bp_data1[%0d] got %h exp %h", i, got1[i], exp1[i]); end end
    $display("test_backpressure done: %0d/%0d results", got0.size(), got1.size());
  endtask

  task automatic test_random();
    bit ok;
    clear_q();
    for (int c = 0; c < 300; c++) begin
      drive(2'($urandom()), 2'($urandom()));
      checks++; if (req_ready !== exp_grant(req_valid)) begin errors++; $display("FAIL rand_grant cycle %0d got %b exp %b", c, req_ready, exp_grant(req_valid)); end
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain timeout outstanding %0d/%0d", outst[0], outst[1]); end
    checks++; if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin errors++; $display("FAIL rand_count got %0d/%0d exp %0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL rand_data0[%0d] got %h exp %h", i, got0[i], exp0[i]); end end
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL rand_data1[%0d] got %h exp %h", i, got1[i], exp1[i]); end end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err got %b exp 0", err); end
    $display("test_random done: %0d/%0d results", got0.size(), got1.size());
  endtask

  task automatic test_err_inject();
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL err_no_push got valid=%b exp 00", resp_valid); end
    repeat (50) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    $display("test_err_inject done");
  endtask

  task automatic test_mid_reset();
    int base;
    int n;
    clear_q();
    base = acc_cnt[0] + acc_cnt[1];
    n = 0;
    while (acc_cnt[0] + acc_cnt[1] - base < 5 && n < 20) begin drive(2'b11, 2'b00); n++; end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (acc_cnt[0] + acc_cnt[1] - base < 5) begin errors++; $display("FAIL mid_fill got %0d accepts exp 5", acc_cnt[0] + acc_cnt[1] - base); end
    n = 0;
    while (resp_valid === 2'b00 && n < 30) begin @(negedge clk); n++; end
    checks++; if (resp_valid === 2'b00) begin errors++; $display("FAIL mid_pre_valid got %b exp nonzero", resp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL mid_async_valid got %b exp 00", resp_valid); end
    checks++; if (err !== 1'b0 || enc_plain !== 128'h0) begin errors++; $display("FAIL mid_async_clear got err=%b enc_plain=%h exp 0/0", err, enc_plain); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    drive(2'b01, 2'b00);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_grant got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    resp_ready = 2'b11;
    repeat (40) @(negedge clk);
    resp_ready = 2'b00;
    checks++; if (got0.size() != 1 || got1.size() != 0) begin errors++; $display("FAIL mid_count got %0d/%0d exp 1/0", got0.size(), got1.size()); end
    if (got0.size() == 1 && exp0.size() == 1) begin
      checks++; if (got0[0] !== exp0[0]) begin errors++; $display("FAIL mid_data got %h exp %h", got0[0], exp0[0]); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b exp 0", err); end
    $display("test_mid_reset done");
  endtask

  initial begin
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    build_sbox();
    test_reset();
    test_single_block();
    test_round_robin();
    test_backpressure();
    test_random();
    test_err_inject();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
